packet_rr_arbiter: RTL and testbench

- Output-port arbiter for the NOC router.
- Shares one output link between NUM_REQ input ports using round-robin.
- Holds each grant for one whole fixed-length packet of PKT_FLITS flits, counting flit transfers internally.
- Sits between the input buffers and the crossbar select; its grant drives the crossbar mux.

---
 rtl/packet_rr_arbiter.sv | 110 +++++++++++
 tb/tb_packet_rr_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/packet_rr_arbiter.sv
// Round-robin output-link arbiter for the NOC router: grants one input port per
// fixed-length packet and holds the grant until the last flit has transferred.
module packet_rr_arbiter #(
    parameter int NUM_REQ   = 5,
    parameter int PKT_FLITS = 5,
    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W    = $clog2(PKT_FLITS) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               out_ready_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               busy_o,
    output logic               xfer_o,
    output logic               pkt_last_o,
    output logic [CNT_W-1:0]   flit_cnt_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic [IDX_W-1:0]   idx_n, last_idx, last_n;
    logic [CNT_W-1:0]   cnt_n;
    logic [NUM_REQ-1:0] req_m;
    logic [IDX_W:0]     pick_m, pick_u, pick;

    // Returns {found, index} of the first requester after 'last', wrapping.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   last);
        logic [IDX_W:0] res;
        int p;
        res = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            p = int'(last) + i;
            if (p >= NUM_REQ) p = p - NUM_REQ;
            if (req[p]) res = {1'b1, IDX_W'(p)};
        end
        return res;
    endfunction

    assign busy_o     = (state == BUSY);
    assign xfer_o     = busy_o & req_i[gnt_idx_o] & out_ready_i;
    assign pkt_last_o = xfer_o & (flit_cnt_o == CNT_W'(PKT_FLITS - 1));

    always_comb begin
        req_m = req_i;
        if (state == BUSY) req_m[gnt_idx_o] = 1'b0;
        pick_m = rr_pick(req_m, last_idx);
        pick_u = rr_pick(req_i, last_idx);
        // The current owner only gets a back-to-back packet when nobody else asks.
        pick   = pick_m[IDX_W] ? pick_m : pick_u;
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt_o;
        idx_n   = gnt_idx_o;
        cnt_n   = flit_cnt_o;
        last_n  = last_idx;
        case (state)
            IDLE: begin
                if (pick[IDX_W]) begin
                    state_n             = BUSY;
                    gnt_n               = '0;
                    gnt_n[pick[IDX_W-1:0]] = 1'b1;
                    idx_n               = pick[IDX_W-1:0];
                    cnt_n               = '0;
                end
            end
            BUSY: begin
                if (pkt_last_o) begin
                    last_n = gnt_idx_o;
                    cnt_n  = '0;
                    if (pick[IDX_W]) begin
                        gnt_n                  = '0;
                        gnt_n[pick[IDX_W-1:0]] = 1'b1;
                        idx_n                  = pick[IDX_W-1:0];
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        idx_n   = '0;
                    end
                end else if (xfer_o) begin
                    cnt_n = flit_cnt_o + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gnt_o      <= '0;
            gnt_idx_o  <= '0;
            flit_cnt_o <= '0;
            last_idx   <= IDX_W'(NUM_REQ - 1);
        end else begin
            state      <= state_n;
            gnt_o      <= gnt_n;
            gnt_idx_o  <= idx_n;
            flit_cnt_o <= cnt_n;
            last_idx   <= last_n;
        end
    end

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Scoreboard bench for packet_rr_arbiter: expected flit transfers are queued by
// the stimulus and popped by a monitor on every xfer_o.
module tb_packet_rr_arbiter;

    localparam int NR = 5;
    localparam int PF = 5;
    localparam int IW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NR-1:0] req_i = '0;
    logic          out_ready_i = 1'b1;
    logic [NR-1:0] gnt_o;
    logic [IW-1:0] gnt_idx_o;
    logic          busy_o, xfer_o, pkt_last_o;
    logic [CW-1:0] flit_cnt_o;

    packet_rr_arbiter #(.NUM_REQ(NR), .PKT_FLITS(PF)) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .out_ready_i(out_ready_i),
        .gnt_o(gnt_o), .gnt_idx_o(gnt_idx_o), .busy_o(busy_o), .xfer_o(xfer_o),
        .pkt_last_o(pkt_last_o), .flit_cnt_o(flit_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [CW-1:0] cnt;
        logic          last;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int p);
        exp_t e;
        for (int c = 0; c < PF; c++) begin
            e.idx  = IW'(p);
            e.cnt  = CW'(c);
            e.last = (c == PF - 1);
            sbq.push_back(e);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        req_i       = '0;
        out_ready_i = 1'b1;
        reset       = 1'b1;
        tick(2);
        reset       = 1'b0;
    endtask

    // Monitor: invariants every cycle, scoreboard pop on every transfer.
    always @(negedge clk) begin
        exp_t e;
        chk("gnt_onehot0", 32'($onehot0(gnt_o)), 32'd1);
        chk("busy_vs_gnt", 32'(busy_o), 32'(gnt_o != '0));
        if (xfer_o) begin
            if (sbq.size() == 0) begin
                chk("xfer_expected", 32'(sbq.size()), 32'd1);
            end else begin
                e = sbq.pop_front();
                chk("xfer_idx", 32'(gnt_idx_o), 32'(e.idx));
                chk("xfer_gnt", 32'(gnt_o), 32'(1) << e.idx);
                chk("xfer_cnt", 32'(flit_cnt_o), 32'(e.cnt));
                chk("xfer_last", 32'(pkt_last_o), 32'(e.last));
            end
        end
    end

    initial begin
        do_reset();
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_idx", 32'(gnt_idx_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_cnt", 32'(flit_cnt_o), 32'd0);
        chk("rst_xfer", 32'(xfer_o), 32'd0);

        // Sole requester: granted after one cycle, regranted with no idle gap.
        req_i = 5'b00100;
        chk("arb_cycle_no_xfer", 32'(xfer_o), 32'd0);
        push_pkt(2); push_pkt(2);
        tick(1);
        chk("s1_grant", 32'(gnt_o), 32'b00100);
        tick(10);
        chk("s1_drained", 32'(sbq.size()), 32'd0);
        chk("s1_regrant", 32'(gnt_o), 32'b00100);
        chk("s1_still_busy", 32'(busy_o), 32'd1);
        do_reset();

        // Two requesters alternate without bubbles.
        req_i = 5'b00011;
        push_pkt(0); push_pkt(1); push_pkt(0); push_pkt(1);
        tick(21);
        chk("s2_drained", 32'(sbq.size()), 32'd0);
        do_reset();

        // Downstream stall for three cycles at flit 2.
        req_i = 5'b00100;
        push_pkt(2);
        tick(3);
        for (int k = 0; k < 3; k++) begin
            out_ready_i = 1'b0;
            #1;
            chk("s3_stall_xfer", 32'(xfer_o), 32'd0);
            chk("s3_stall_cnt", 32'(flit_cnt_o), 32'd2);
            chk("s3_stall_gnt", 32'(gnt_o), 32'b00100);
            tick(1);
        end
        out_ready_i = 1'b1;
        tick(2);
        chk("s3_one_left", 32'(sbq.size()), 32'd1);
        tick(1);
        chk("s3_drained", 32'(sbq.size()), 32'd0);
        do_reset();

        // Granted port drops its request mid-packet; grant is held, then wrap 4->0.
        req_i = 5'b10000;
        push_pkt(4);
        tick(3);
        for (int k = 0; k < 3; k++) begin
            req_i = 5'b00001;
            #1;
            chk("s4_hold_gnt", 32'(gnt_o), 32'b10000);
            chk("s4_hold_xfer", 32'(xfer_o), 32'd0);
            chk("s4_hold_cnt", 32'(flit_cnt_o), 32'd2);
            tick(1);
        end
        req_i = 5'b10001;
        push_pkt(0);
        tick(3);
        chk("s4_wrap_gnt", 32'(gnt_o), 32'b00001);
        tick(5);
        chk("s4_drained", 32'(sbq.size()), 32'd0);
        do_reset();

        // Reset in the middle of a packet abandons it; port 0 first afterwards.
        req_i = 5'b00010;
        sbq.push_back('{idx: IW'(1), cnt: CW'(0), last: 1'b0});
        sbq.push_back('{idx: IW'(1), cnt: CW'(1), last: 1'b0});
        sbq.push_back('{idx: IW'(1), cnt: CW'(2), last: 1'b0});
        sbq.push_back('{idx: IW'(1), cnt: CW'(3), last: 1'b0});
        tick(4);
        chk("s5_cnt3", 32'(flit_cnt_o), 32'd3);
        reset = 1'b1;
        tick(1);
        chk("s5_rst_gnt", 32'(gnt_o), 32'd0);
        chk("s5_rst_busy", 32'(busy_o), 32'd0);
        chk("s5_rst_cnt", 32'(flit_cnt_o), 32'd0);
        reset = 1'b0;
        req_i = 5'b11111;
        push_pkt(0);
        tick(1);
        chk("s5_first_gnt", 32'(gnt_o), 32'b00001);
        tick(5);
        chk("s5_drained", 32'(sbq.size()), 32'd0);
        do_reset();

        // All ports requesting: full rotation 0..4 then back to 0.
        req_i = 5'b11111;
        push_pkt(0); push_pkt(1); push_pkt(2); push_pkt(3); push_pkt(4); push_pkt(0);
        tick(31);
        chk("s6_drained", 32'(sbq.size()), 32'd0);
        chk("s6_next_gnt", 32'(gnt_o), 32'b00010);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
